piso_stream_ser: RTL and testbench
==================================

# piso_stream_ser

Parametrised parallel-in/serial-out serializer, the successor to the fixed 4-bit PISO register. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per enabled cycle, MSB-first or LSB-first. It flags the first and last bit of each word and supports back-to-back words with no idle cycle. It sits between a parallel producer (bus or FIFO) and a bit-serial link or a downstream SIPO.

## Interface
- WIDTH, 8, word width in bits; legal range 2..64.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_LEVEL, 0, value driven on q_serial when no word is in flight.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- load_valid  in  1  producer has a word on d_in.
- load_ready  out  1  serializer can accept a word this cycle.
- d_in  in  WIDTH  parallel word; sampled only on handshake.
- shift_en  in  1  bit-rate enable; a bit advances only on cycles where it is 1.
- q_serial  out  1  current serial bit.
- q_valid  out  1  q_serial carries a data bit.
- q_first  out  1  current bit is the first bit of its word.
- q_last  out  1  current bit is the last bit of its word.
- q_parallel  out  WIDTH  raw shift-register contents, for debug and observation.
- busy  out  1  a word is in flight.

## Operation
- Two states:
  - IDLE: no word in flight.
  - SHIFT: word in flight.
- Bit counter cnt is $clog2(WIDTH) bits wide and counts 0..WIDTH-1 bits sent.
- Handshake: a load is accepted when load_valid && load_ready.
  - load_ready = !reset && (state==IDLE || (state==SHIFT && cnt==WIDTH-1 && shift_en)).
- On accept:
  - shift register <= d_in, cnt <= 0, state <= SHIFT.
  - A load accepted together with the final shift replaces the old word without a gap.
- In SHIFT with shift_en=1 and cnt<WIDTH-1:
  - MSB_FIRST: shift register shifts left and fills with 0.
  - LSB-first: shift register shifts right and fills with 0.
  - cnt increments.
- In SHIFT with shift_en=1, cnt==WIDTH-1, and no new load: state <= IDLE and the shift register clears to 0.
- shift_en=0 holds all state and outputs, in any state.
- load_valid while busy and not at the final enabled bit: the word is ignored; the producer must hold it until load_ready.
- Outputs:
  - q_serial = IDLE_LEVEL in IDLE; otherwise shift register bit WIDTH-1 (MSB_FIRST) or bit 0 (LSB-first).
  - q_valid = busy = (state==SHIFT).
  - q_first = q_valid && cnt==0.
  - q_last = q_valid && cnt==WIDTH-1.
- Reset, including mid-word: state IDLE, cnt 0, shift register 0, q_serial IDLE_LEVEL, q_valid/q_first/q_last/busy 0, load_ready 0. The in-flight word is discarded; no partial-word flag is raised.
- Reset wins over a simultaneous load.

## Timing
- Load latency: a word accepted at edge N presents its first bit on q_serial right after edge N (q_first=1).
- A word occupies exactly WIDTH enabled cycles. With shift_en tied high it lasts WIDTH clk cycles; sustained throughput is 1 bit per clk.
- Back-to-back:
  - Word A's last bit is in the cycle before edge M.
  - Word B is accepted at edge M.
  - Word B's first bit appears right after edge M, so q_valid stays high continuously.
- load_ready is combinational from state, cnt, shift_en and reset. d_in and load_valid must not depend combinationally on load_ready.
- All other outputs are registered-state decodes; there is no combinational path from d_in to any output.

## Structure
- Shared package piso_pkg:
  - state enum {ST_IDLE, ST_SHIFT}.
  - Counter-width localparam helper for $clog2(WIDTH).
  - Reset-value constants.
- One natural sub-module: piso_bit_counter.
  - Ports: clk, reset, clr, en; outputs cnt and at_last.
  - Reused later by the matching parametrised SIPO.
- The rest of the block is a single module: the state register, shift register and output decode.

## Test plan
- WIDTH=4, MSB_FIRST=1, shift_en=1; load 4'b1011 -> q_serial 1,0,1,1 over 4 cycles; q_first on cycle 1; q_last on cycle 4; busy drops after cycle 4; q_serial returns to IDLE_LEVEL.
- Same word with MSB_FIRST=0 -> q_serial 1,1,0,1.
- Same word with shift_en toggling 1,0,1,0,... -> the same 4-bit sequence, each bit held for 2 cycles; q_last lasts 2 cycles; no bit is lost or duplicated.
- Back-to-back 4'b1011 then 4'b0110 (MSB_FIRST, load_valid held high) -> 8 contiguous bits 1,0,1,1,0,1,1,0; q_valid never drops; load_ready is high only in the cycles where a load can be accepted (idle, or the last bit of A); q_first on bits 1 and 5.
- Reset asserted after 2 bits of 4'b1011 -> next cycle all outputs are at reset values and load_ready=0; after release, load 4'b0001 serializes correctly as 0,0,0,1.
- load_valid with 4'b1111 held while busy mid-word -> no corruption of the current word; 4'b1111 is accepted exactly once, on the last bit; WIDTH=8 variant sends 8'hA5 as 1,0,1,0,0,1,0,1.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parametrised PISO/SIPO serializer family.
package piso_pkg;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  // Counter width for a WIDTH-bit word; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam state_e RST_STATE = ST_IDLE;
  localparam logic   RST_BIT   = 1'b0;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter: counts 0..WIDTH-1 and flags the final position.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CntW  = cnt_width(WIDTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  output logic [CntW-1:0] cnt,
  output logic            at_last
);

  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign cnt     = r_cnt;
  assign at_last = (r_cnt == LastCnt);

endmodule

// File: rtl/piso_stream_ser.sv
// Parametrised parallel-in/serial-out serializer with valid/ready load and first/last flags.
module piso_stream_ser #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] d_in,
  input  logic             shift_en,
  output logic             q_serial,
  output logic             q_valid,
  output logic             q_first,
  output logic             q_last,
  output logic [WIDTH-1:0] q_parallel,
  output logic             busy
);

  import piso_pkg::*;

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [CntW-1:0]  w_cnt;
  logic             w_at_last;
  logic             w_shifting;
  logic             w_final;
  logic             w_accept;

  assign w_shifting = (r_state == ST_SHIFT) && shift_en;
  assign w_final    = w_shifting && w_at_last;
  // A load at the final enabled bit replaces the old word with no idle gap.
  assign load_ready = !reset && ((r_state == ST_IDLE) || w_final);
  assign w_accept   = load_valid && load_ready;

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CntW  (CntW)
  ) u_bit_counter (
    .clk     (clk),
    .reset   (reset),
    .clr     (w_accept || w_final),
    .en      (w_shifting && !w_at_last),
    .cnt     (w_cnt),
    .at_last (w_at_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RST_STATE;
      r_sr    <= {WIDTH{RST_BIT}};
    end else if (w_accept) begin
      r_state <= ST_SHIFT;
      r_sr    <= d_in;
    end else if (w_final) begin
      r_state <= ST_IDLE;
      r_sr    <= '0;
    end else if (w_shifting) begin
      r_sr <= MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
    end
  end

  assign q_valid    = (r_state == ST_SHIFT);
  assign busy       = q_valid;
  assign q_first    = q_valid && (w_cnt == '0);
  assign q_last     = q_valid && w_at_last;
  assign q_serial   = q_valid ? (MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0]) : IDLE_LEVEL;
  assign q_parallel = r_sr;

endmodule

// File: tb/tb_piso_stream_ser.sv
// Table-driven bench: two 4-bit serializers (MSB/LSB-first) side by side plus an 8-bit instance.
module tb_piso_stream_ser;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic       lv8 = 1'b0;
  logic       shift_en = 1'b1;
  logic [3:0] d4 = '0;
  logic [7:0] d8 = '0;

  logic       m_rdy, m_ser, m_val, m_first, m_last, m_busy;
  logic [3:0] m_par;
  logic       l_rdy, l_ser, l_val, l_first, l_last, l_busy;
  logic [3:0] l_par;
  logic       c_rdy, c_ser, c_val, c_first, c_last, c_busy;
  logic [7:0] c_par;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_stream_ser #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb4 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(m_rdy), .d_in(d4),
    .shift_en(shift_en), .q_serial(m_ser), .q_valid(m_val), .q_first(m_first),
    .q_last(m_last), .q_parallel(m_par), .busy(m_busy)
  );

  piso_stream_ser #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb4 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(l_rdy), .d_in(d4),
    .shift_en(shift_en), .q_serial(l_ser), .q_valid(l_val), .q_first(l_first),
    .q_last(l_last), .q_parallel(l_par), .busy(l_busy)
  );

  piso_stream_ser #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb8 (
    .clk(clk), .reset(reset), .load_valid(lv8), .load_ready(c_rdy), .d_in(d8),
    .shift_en(shift_en), .q_serial(c_ser), .q_valid(c_val), .q_first(c_first),
    .q_last(c_last), .q_parallel(c_par), .busy(c_busy)
  );

  typedef struct {
    logic       rst;
    logic       lv;
    logic       se;
    logic [3:0] d;
    logic       e_rdy;
    logic       e_val;
    logic       e_first;
    logic       e_last;
    logic [3:0] e_pm;   // expected shift register, MSB-first instance
    logic [3:0] e_pl;   // expected shift register, LSB-first instance
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic lv, input logic se, input logic [3:0] d,
                     input logic rdy, input logic val, input logic first, input logic last,
                     input logic [3:0] pm, input logic [3:0] pl);
    vec_t v;
    v = '{rst, lv, se, d, rdy, val, first, last, pm, pl};
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Reset state, then idle.
    add(1, 0, 1, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000);
    add(0, 0, 1, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);
    // Basic word 1011, shift_en high.
    add(0, 1, 1, 4'b1011, 1, 0, 0, 0, 4'b0000, 4'b0000);
    add(0, 0, 1, 4'b0000, 0, 1, 1, 0, 4'b1011, 4'b1011);
    add(0, 0, 1, 4'b0000, 0, 1, 0, 0, 4'b0110, 4'b0101);
    add(0, 0, 1, 4'b0000, 0, 1, 0, 0, 4'b1100, 4'b0010);
    add(0, 0, 1, 4'b0000, 1, 1, 0, 1, 4'b1000, 4'b0001);
    add(0, 0, 1, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);
    // shift_en toggling: each bit held two cycles.
    add(0, 1, 1, 4'b1011, 1, 0, 0, 0, 4'b0000, 4'b0000);
    add(0, 0, 0, 4'b0000, 0, 1, 1, 0, 4'b1011, 4'b1011);
    add(0, 0, 1, 4'b0000, 0, 1, 1, 0, 4'b1011, 4'b1011);
    add(0, 0, 0, 4'b0000, 0, 1, 0, 0, 4'b0110, 4'b0101);
    add(0, 0, 1, 4'b0000, 0, 1, 0, 0, 4'b0110, 4'b0101);
    add(0, 0, 0, 4'b0000, 0, 1, 0, 0, 4'b1100, 4'b0010);
    add(0, 0, 1, 4'b0000, 0, 1, 0, 0, 4'b1100, 4'b0010);
    add(0, 0, 0, 4'b0000, 0, 1, 0, 1, 4'b1000, 4'b0001);
    add(0, 0, 1, 4'b0000, 1, 1, 0, 1, 4'b1000, 4'b0001);
    add(0, 0, 0, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);
    // Back-to-back 1011 then 0110 with load_valid held.
    add(0, 1, 1, 4'b1011, 1, 0, 0, 0, 4'b0000, 4'b0000);
    add(0, 1, 1, 4'b0110, 0, 1, 1, 0, 4'b1011, 4'b1011);
    add(0, 1, 1, 4'b0110, 0, 1, 0, 0, 4'b0110, 4'b0101);
    add(0, 1, 1, 4'b0110, 0, 1, 0, 0, 4'b1100, 4'b0010);
    add(0, 1, 1, 4'b0110, 1, 1, 0, 1, 4'b1000, 4'b0001);
    add(0, 0, 1, 4'b0000, 0, 1, 1, 0, 4'b0110, 4'b0110);
    add(0, 0, 1, 4'b0000, 0, 1, 0, 0, 4'b1100, 4'b0011);
    add(0, 0, 1, 4'b0000, 0, 1, 0, 0, 4'b1000, 4'b0001);
    add(0, 0, 1, 4'b0000, 1, 1, 0, 1, 4'b0000, 4'b0000);
    add(0, 0, 1, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);
    // Reset after two bits; reset also beats a simultaneous load of 1111.
    add(0, 1, 1, 4'b1011, 1, 0, 0, 0, 4'b0000, 4'b0000);
    add(0, 0, 1, 4'b0000, 0, 1, 1, 0, 4'b1011, 4'b1011);
    add(0, 0, 1, 4'b0000, 0, 1, 0, 0, 4'b0110, 4'b0101);
    add(1, 1, 1, 4'b1111, 0, 1, 0, 0, 4'b1100, 4'b0010);
    add(1, 1, 1, 4'b1111, 0, 0, 0, 0, 4'b0000, 4'b0000);
    add(0, 1, 1, 4'b0001, 1, 0, 0, 0, 4'b0000, 4'b0000);
    add(0, 0, 1, 4'b0000, 0, 1, 1, 0, 4'b0001, 4'b0001);
    add(0, 0, 1, 4'b0000, 0, 1, 0, 0, 4'b0010, 4'b0000);
    add(0, 0, 1, 4'b0000, 0, 1, 0, 0, 4'b0100, 4'b0000);
    add(0, 0, 1, 4'b0000, 1, 1, 0, 1, 4'b1000, 4'b0000);
    add(0, 0, 1, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);
    // 1111 offered mid-word: accepted once, at the final bit.
    add(0, 1, 1, 4'b1011, 1, 0, 0, 0, 4'b0000, 4'b0000);
    add(0, 0, 1, 4'b0000, 0, 1, 1, 0, 4'b1011, 4'b1011);
    add(0, 1, 1, 4'b1111, 0, 1, 0, 0, 4'b0110, 4'b0101);
    add(0, 1, 1, 4'b1111, 0, 1, 0, 0, 4'b1100, 4'b0010);
    add(0, 1, 1, 4'b1111, 1, 1, 0, 1, 4'b1000, 4'b0001);
    add(0, 0, 1, 4'b0000, 0, 1, 1, 0, 4'b1111, 4'b1111);
    add(0, 0, 1, 4'b0000, 0, 1, 0, 0, 4'b1110, 4'b0111);
    add(0, 0, 1, 4'b0000, 0, 1, 0, 0, 4'b1100, 4'b0011);
    add(0, 0, 1, 4'b0000, 1, 1, 0, 1, 4'b1000, 4'b0001);
    add(0, 0, 1, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);

    @(posedge clk);
    foreach (vq[i]) begin
      logic e_sm, e_sl;
      @(negedge clk);
      reset      = vq[i].rst;
      load_valid = vq[i].lv;
      shift_en   = vq[i].se;
      d4         = vq[i].d;
      #1;
      e_sm = vq[i].e_val ? vq[i].e_pm[3] : 1'b0;
      e_sl = vq[i].e_val ? vq[i].e_pl[0] : 1'b1;
      chk($sformatf("row%0d m_load_ready", i), 8'(m_rdy), 8'(vq[i].e_rdy));
      chk($sformatf("row%0d l_load_ready", i), 8'(l_rdy), 8'(vq[i].e_rdy));
      chk($sformatf("row%0d m_q_valid", i), 8'(m_val), 8'(vq[i].e_val));
      chk($sformatf("row%0d l_q_valid", i), 8'(l_val), 8'(vq[i].e_val));
      chk($sformatf("row%0d m_busy", i), 8'(m_busy), 8'(vq[i].e_val));
      chk($sformatf("row%0d m_q_first", i), 8'(m_first), 8'(vq[i].e_first));
      chk($sformatf("row%0d l_q_first", i), 8'(l_first), 8'(vq[i].e_first));
      chk($sformatf("row%0d m_q_last", i), 8'(m_last), 8'(vq[i].e_last));
      chk($sformatf("row%0d l_q_last", i), 8'(l_last), 8'(vq[i].e_last));
      chk($sformatf("row%0d m_q_parallel", i), 8'(m_par), 8'(vq[i].e_pm));
      chk($sformatf("row%0d l_q_parallel", i), 8'(l_par), 8'(vq[i].e_pl));
      chk($sformatf("row%0d m_q_serial", i), 8'(m_ser), 8'(e_sm));
      chk($sformatf("row%0d l_q_serial", i), 8'(l_ser), 8'(e_sl));
    end

    // WIDTH=8: 8'hA5 leaves MSB-first as 1,0,1,0,0,1,0,1.
    begin
      logic [7:0] exp_bits;
      exp_bits = 8'b1010_0101;
      @(negedge clk);
      load_valid = 1'b0;
      shift_en   = 1'b1;
      lv8        = 1'b1;
      d8         = 8'hA5;
      #1;
      chk("w8 load_ready idle", 8'(c_rdy), 8'd1);
      chk("w8 q_valid idle", 8'(c_val), 8'd0);
      for (int b = 0; b < 8; b++) begin
        @(negedge clk);
        lv8 = 1'b0;
        d8  = 8'h00;
        #1;
        chk($sformatf("w8 bit%0d q_serial", b), 8'(c_ser), 8'(exp_bits[7-b]));
        chk($sformatf("w8 bit%0d q_valid", b), 8'(c_val), 8'd1);
        chk($sformatf("w8 bit%0d q_first", b), 8'(c_first), 8'(b == 0));
        chk($sformatf("w8 bit%0d q_last", b), 8'(c_last), 8'(b == 7));
      end
      @(negedge clk);
      #1;
      chk("w8 end busy", 8'(c_busy), 8'd0);
      chk("w8 end q_serial", 8'(c_ser), 8'd0);
      chk("w8 end q_parallel", c_par, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
